// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Single-outstanding-request instruction fetch stage. Issues a request at PC,
// waits for the memory response, holds the instruction until downstream
// accepts it, then loads the next PC supplied by the PC path.
//
// States: StFetch (request out), StHold (instruction presented), StDrop
// (absorbing the response of a flushed request), and StHalt (misaligned PC,
// only when FETCH_ALIGN_CHECK_EN is defined).
//
// Optional feature macro: FETCH_ALIGN_CHECK_EN
//   Defined   : any PC load with PC[1:0] != 0 parks the fetcher in StHalt until
//               a flush to an aligned target or a reset.
//   Undefined : no StHalt; PC[1:0] goes to imem_addr unchecked.
//
// Ports
//   clk          in   clock, rising edge
//   reset        in   asynchronous active-high reset
//   PC           out  current fetch PC
//   PCNew        in   next PC from the PC path, sampled at handoff only
//   flush        in   redirect request, discards in-flight work
//   flush_pc     in   redirect target
//   imem_req     out  instruction memory request
//   imem_addr    out  request address (equals PC)
//   imem_ack     in   memory response strobe
//   imem_rdata   in   instruction word, valid with imem_ack
//   instr_valid  out  instruction presented downstream
//   instr        out  registered instruction
//   instr_pc     out  PC of the presented instruction
//   instr_ready  in   downstream accept
//   fetch_cnt    out  count of handed-off instructions (wraps)
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] PC,
    input  logic [63:0] PCNew,
    input  logic        flush,
    input  logic [63:0] flush_pc,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [63:0] instr_pc,
    input  logic        instr_ready,
    output logic [31:0] fetch_cnt
);

`ifdef FETCH_ALIGN_CHECK_EN
    typedef enum logic [1:0] {StFetch, StHold, StDrop, StHalt} state_e;
`else
    typedef enum logic [1:0] {StFetch, StHold, StDrop} state_e;
`endif

    state_e      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [63:0] instr_pc_q, instr_pc_d;
    logic        instr_valid_q, instr_valid_d;
    logic [31:0] fetch_cnt_q, fetch_cnt_d;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        fetch_cnt_d   = fetch_cnt_q;

        unique case (state_q)
            StFetch: begin
                if (flush) begin
                    // With a same-cycle ack the request is already retired, so
                    // refetch directly; otherwise its response is still owed.
                    pc_d    = flush_pc;
                    state_d = imem_ack ? StFetch : StDrop;
                end else if (imem_ack) begin
                    instr_d       = imem_rdata;
                    instr_pc_d    = pc_q;
                    instr_valid_d = 1'b1;
                    state_d       = StHold;
                end
            end
            StHold: begin
                // Flush wins over a simultaneous accept: nothing is counted.
                if (flush) begin
                    instr_valid_d = 1'b0;
                    pc_d          = flush_pc;
                    state_d       = StFetch;
                end else if (instr_ready) begin
                    instr_valid_d = 1'b0;
                    pc_d          = PCNew;
                    fetch_cnt_d   = fetch_cnt_q + 32'd1;
                    state_d       = StFetch;
                end
            end
            StDrop: begin
                if (flush) begin
                    pc_d = flush_pc;
                end
                if (imem_ack) begin
                    state_d = StFetch;
                end
            end
`ifdef FETCH_ALIGN_CHECK_EN
            StHalt: begin
                if (flush) begin
                    pc_d    = flush_pc;
                    state_d = StFetch;
                end
            end
`endif
            default: state_d = StFetch;
        endcase

`ifdef FETCH_ALIGN_CHECK_EN
        // PC is always aligned outside StHalt, so a misaligned pc_d can only
        // come from a load in this cycle.
        if (pc_d[1:0] != 2'b00) begin
            state_d       = StHalt;
            instr_valid_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
`ifdef FETCH_ALIGN_CHECK_EN
            state_q <= (RESET_PC[1:0] != 2'b00) ? StHalt : StFetch;
`else
            state_q <= StFetch;
`endif
            pc_q          <= RESET_PC;
            instr_q       <= 32'h0;
            instr_pc_q    <= 64'h0;
            instr_valid_q <= 1'b0;
            fetch_cnt_q   <= 32'h0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            fetch_cnt_q   <= fetch_cnt_d;
        end
    end

    // Combinational from state so the first request leaves in the first cycle
    // after reset release; gated by reset since state already reads StFetch.
    assign imem_req    = (state_q == StFetch) && !reset;
    assign imem_addr   = pc_q;
    assign PC          = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign fetch_cnt   = fetch_cnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//
// Directed self-checking bench for instr_fetch. Inputs change 1 ns after the
// rising edge and outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

    logic        clk;
    logic        reset;
    logic [63:0] PC;
    logic [63:0] PCNew;
    logic        flush;
    logic [63:0] flush_pc;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        instr_ready;
    logic [31:0] fetch_cnt;

    int n_asserts = 0;
    int n_fail    = 0;

    instr_fetch dut (
        .clk         (clk),
        .reset       (reset),
        .PC          (PC),
        .PCNew       (PCNew),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .fetch_cnt   (fetch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset       = 1'b1;
        PCNew       = 64'h0;
        flush       = 1'b0;
        flush_pc    = 64'h0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        instr_ready = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_pc", PC, 64'h0);
        chk("rst_valid", 64'(instr_valid), 64'd0);
        chk("rst_instr", 64'(instr), 64'h0);
        chk("rst_instr_pc", instr_pc, 64'h0);
        chk("rst_cnt", 64'(fetch_cnt), 64'd0);
        chk("rst_req", 64'(imem_req), 64'd0);

        // First request in the first cycle after release
        reset = 1'b0;
        #1;
        chk("post_rst_req", 64'(imem_req), 64'd1);
        chk("post_rst_addr", imem_addr, 64'h0);

        // Basic fetch with two-cycle ack, immediate handoff
        instr_ready = 1'b1;
        PCNew       = 64'h4;
        tick();
        chk("t1_req_held", 64'(imem_req), 64'd1);
        chk("t1_no_valid", 64'(instr_valid), 64'd0);
        imem_ack   = 1'b1;
        imem_rdata = 32'h8B020020;
        tick();
        imem_ack = 1'b0;
        chk("t1_valid", 64'(instr_valid), 64'd1);
        chk("t1_instr", 64'(instr), 64'h8B020020);
        chk("t1_instr_pc", instr_pc, 64'h0);
        chk("t1_hold_req", 64'(imem_req), 64'd0);
        tick();
        chk("t1_pc", PC, 64'h4);
        chk("t1_cnt", 64'(fetch_cnt), 64'd1);
        chk("t1_valid_drop", 64'(instr_valid), 64'd0);
        chk("t1_next_addr", imem_addr, 64'h4);
        chk("t1_next_req", 64'(imem_req), 64'd1);

        // Backpressure in HOLD; a stray ack there must be ignored
        instr_ready = 1'b0;
        imem_ack    = 1'b1;
        imem_rdata  = 32'h12345678;
        tick();
        imem_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                imem_ack   = 1'b1;
                imem_rdata = 32'hDEADBEEF;
            end else begin
                imem_ack = 1'b0;
            end
            tick();
            chk("t2_instr", 64'(instr), 64'h12345678);
            chk("t2_instr_pc", instr_pc, 64'h4);
            chk("t2_req", 64'(imem_req), 64'd0);
            chk("t2_cnt", 64'(fetch_cnt), 64'd1);
            chk("t2_valid", 64'(instr_valid), 64'd1);
        end
        imem_ack    = 1'b0;
        PCNew       = 64'h8;
        instr_ready = 1'b1;
        tick();
        chk("t2_pc", PC, 64'h8);
        chk("t2_cnt_after", 64'(fetch_cnt), 64'd2);

        // Flush one cycle after request, ack arrives later and is dropped
        instr_ready = 1'b0;
        tick();
        flush    = 1'b1;
        flush_pc = 64'h100;
        tick();
        flush = 1'b0;
        chk("t3_drop_req", 64'(imem_req), 64'd0);
        chk("t3_drop_pc", PC, 64'h100);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("t3_wait_req", 64'(imem_req), 64'd0);
            chk("t3_wait_valid", 64'(instr_valid), 64'd0);
        end
        imem_ack   = 1'b1;
        imem_rdata = 32'hAAAA5555;
        tick();
        imem_ack = 1'b0;
        chk("t3_refetch_req", 64'(imem_req), 64'd1);
        chk("t3_refetch_addr", imem_addr, 64'h100);
        chk("t3_no_valid", 64'(instr_valid), 64'd0);
        tick();
        chk("t3_no_valid2", 64'(instr_valid), 64'd0);
        chk("t3_instr_kept", 64'(instr), 64'h12345678);

        // Flush in HOLD with instr_ready=1: no handoff
        imem_ack   = 1'b1;
        imem_rdata = 32'h11111111;
        tick();
        imem_ack = 1'b0;
        chk("t4_valid", 64'(instr_valid), 64'd1);
        chk("t4_instr_pc", instr_pc, 64'h100);
        instr_ready = 1'b1;
        flush       = 1'b1;
        flush_pc    = 64'h200;
        PCNew       = 64'h104;
        tick();
        flush       = 1'b0;
        instr_ready = 1'b0;
        chk("t4_valid_off", 64'(instr_valid), 64'd0);
        chk("t4_cnt", 64'(fetch_cnt), 64'd2);
        chk("t4_addr", imem_addr, 64'h200);
        chk("t4_req", 64'(imem_req), 64'd1);

        // Flush with same-cycle ack in FETCH: stay in FETCH at new PC
        flush      = 1'b1;
        flush_pc   = 64'h300;
        imem_ack   = 1'b1;
        imem_rdata = 32'h22222222;
        tick();
        flush    = 1'b0;
        imem_ack = 1'b0;
        chk("t5_req", 64'(imem_req), 64'd1);
        chk("t5_addr", imem_addr, 64'h300);
        chk("t5_valid", 64'(instr_valid), 64'd0);
        chk("t5_instr", 64'(instr), 64'h11111111);

        // Counter wrap
        imem_ack   = 1'b1;
        imem_rdata = 32'h33333333;
        tick();
        imem_ack = 1'b0;
        force dut.fetch_cnt_q = 32'hFFFFFFFF;
        tick();
        release dut.fetch_cnt_q;
        chk("t6_preload", 64'(fetch_cnt), 64'hFFFFFFFF);
        instr_ready = 1'b1;
        PCNew       = 64'h304;
        tick();
        instr_ready = 1'b0;
        chk("t6_wrap", 64'(fetch_cnt), 64'd0);
        chk("t6_pc", PC, 64'h304);

        // Asynchronous reset mid-request
        reset = 1'b1;
        #1;
        chk("t7_req", 64'(imem_req), 64'd0);
        chk("t7_pc", PC, 64'h0);
        tick();
        reset = 1'b0;
        #1;
        chk("t7_rel_req", 64'(imem_req), 64'd1);
        chk("t7_rel_addr", imem_addr, 64'h0);

        // Misaligned handoff target
        imem_ack   = 1'b1;
        imem_rdata = 32'h44444444;
        tick();
        imem_ack    = 1'b0;
        PCNew       = 64'h6;
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("t8_pc", PC, 64'h6);
        chk("t8_valid", 64'(instr_valid), 64'd0);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("t8_halt_req", 64'(imem_req), 64'd0);
        tick();
        chk("t8_halt_req2", 64'(imem_req), 64'd0);
        flush    = 1'b1;
        flush_pc = 64'h8;
        tick();
        flush = 1'b0;
        chk("t8_resume_req", 64'(imem_req), 64'd1);
        chk("t8_resume_addr", imem_addr, 64'h8);
`else
        chk("t8_unchecked_req", 64'(imem_req), 64'd1);
        chk("t8_unchecked_addr", imem_addr, 64'h6);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 64'h0, which is the PC value loaded on reset.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-004 The block SHALL have port PC, output, 64 bits, the current fetch PC, driven to the PC path.
REQ-005 The block SHALL have port PCNew, input, 64 bits, the next PC from the PC path, sampled only at handoff.
REQ-006 The block SHALL have port flush, input, 1 bit, a redirect request that discards in-flight work.
REQ-007 The block SHALL have port flush_pc, input, 64 bits, the redirect target.
REQ-008 The block SHALL have port imem_req, output, 1 bit, the instruction memory request.
REQ-009 The block SHALL have port imem_addr, output, 64 bits, the request address, equal to PC.
REQ-010 The block SHALL have port imem_ack, input, 1 bit, memory response strobe (latency 1..N cycles).
REQ-011 The block SHALL have port imem_rdata, input, 32 bits, the instruction word, valid with imem_ack.
REQ-012 The block SHALL have port instr_valid, output, 1 bit, marking the instruction as presented downstream.
REQ-013 The block SHALL have port instr, output, 32 bits, the registered instruction.
REQ-014 The block SHALL have port instr_pc, output, 64 bits, the PC of the presented instruction.
REQ-015 The block SHALL have port instr_ready, input, 1 bit, downstream accept.
REQ-016 The block SHALL have port fetch_cnt, output, 32 bits, the count of handed-off instructions.

Function
REQ-017 FSM states SHALL be FETCH, HOLD, DROP, and HALT (HALT only with macro).
REQ-018 In FETCH, imem_req=1 and imem_addr=PC held stable until imem_ack; on ack go HOLD with instr<=imem_rdata, instr_pc<=PC, instr_valid<=1 on next cycle.
REQ-019 In HOLD, imem_req=0; the instruction SHALL remain stable until instr_valid&&instr_ready (handoff).
REQ-020 On handoff: PC<=PCNew, instr_valid<=0, fetch_cnt<=fetch_cnt+1, go FETCH; minimum issue interval = ack latency + 2 cycles.
REQ-021 fetch_cnt SHALL wrap 32'hFFFFFFFF -> 0.
REQ-022 flush in FETCH without same-cycle ack: PC<=flush_pc, go DROP (request outstanding, must be absorbed).
REQ-023 flush in FETCH with same-cycle ack: rdata discarded, PC<=flush_pc, stay FETCH.
REQ-024 flush in HOLD: instr_valid<=0, no handoff counted even if instr_ready=1, PC<=flush_pc, go FETCH.
REQ-025 In DROP, imem_req=0; on imem_ack discard rdata and go FETCH; a further flush in DROP updates PC only.
REQ-026 imem_ack in HOLD SHALL be ignored.
REQ-027 instr_valid SHALL never assert in FETCH or DROP.

Reset
REQ-028 On reset assertion (asynchronous): PC=RESET_PC, state=FETCH, instr_valid=0, instr=0, instr_pc=0, fetch_cnt=0.
REQ-029 While reset=1, imem_req SHALL be 0; the first request SHALL issue in the first cycle after deassertion.
REQ-030 Reset mid-request SHALL abandon it; a stale imem_ack in the first post-reset cycle is the memory's responsibility and is not filtered.

Configuration
REQ-031 With macro FETCH_ALIGN_CHECK_EN defined, a PC load (handoff, flush, or reset) whose bits [1:0]!=0 SHALL go to HALT: imem_req=0, instr_valid=0, exit only by flush to an aligned flush_pc or by reset.
REQ-032 Without FETCH_ALIGN_CHECK_EN, HALT SHALL not exist and PC[1:0] SHALL be passed to imem_addr unchecked.

Verification
REQ-033 Reset, ack after 2 cycles with rdata=32'h8B020020, instr_ready=1, PCNew=4 -> instr=8B020020, instr_pc=0, PC=4, fetch_cnt=1.
REQ-034 instr_ready held 0 for 5 cycles in HOLD -> instr/instr_pc stable, imem_req=0, fetch_cnt unchanged.
REQ-035 flush (flush_pc=64'h100) one cycle after request, ack 3 cycles later -> ack data discarded, next imem_addr=64'h100, no instr_valid pulse.
REQ-036 flush with instr_ready=1 in HOLD -> no handoff, fetch_cnt unchanged, next imem_addr=flush_pc.
REQ-037 Preload fetch_cnt to 32'hFFFFFFFF and perform a handoff -> fetch_cnt=0.
REQ-038 With FETCH_ALIGN_CHECK_EN defined, handoff with PCNew=64'h6 -> HALT, imem_req=0; flush_pc=64'h8 -> fetch resumes at 8.
